// File: rtl/lbm_reg_arbiter.sv
// Round-robin write arbiter for a shared bank of reg32 registers.
// One accept per cycle; the accepted write is issued on LD_EN/Data_In
// in the following cycle.
module lbm_reg_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Hold,
  input  logic [NUM_REQ-1:0]         Req_Valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  Req_Addr,
  input  logic [NUM_REQ*WIDTH-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]         Req_Ready,
  output logic [NUM_REGS-1:0]        LD_EN,
  output logic signed [WIDTH-1:0]    Data_In,
  output logic [$clog2(NUM_REQ)-1:0] Grant_Id,
  output logic                       Err_Addr,
  output logic [15:0]                Write_Count
);

  localparam int          GW  = $clog2(NUM_REQ);
  localparam int unsigned NRQ = NUM_REQ;
  localparam int unsigned NRG = NUM_REGS;

  logic [GW-1:0]       r_ptr;
  logic [NUM_REGS-1:0] r_ld_en;
  logic                r_err;
  logic [WIDTH-1:0]    r_data;
  logic [GW-1:0]       r_gid;
  logic [15:0]         r_cnt;

  logic [NUM_REQ-1:0]  w_ready;
  logic                w_accept;
  logic [GW-1:0]       w_gidx;
  logic [GW-1:0]       w_ptr_next;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [WIDTH-1:0]    w_sel_data;
  logic                w_addr_ok;
  logic [NUM_REGS-1:0] w_onehot;

  // Round-robin search of Req_Valid starting at the pointer, wrapping.
  always_comb begin
    int unsigned w_idx;
    logic [GW-1:0] w_i;
    w_ready  = '0;
    w_accept = 1'b0;
    w_gidx   = '0;
    w_idx    = 0;
    w_i      = '0;
    if (!Reset && !Hold) begin
      for (int unsigned k = 0; k < NRQ; k++) begin
        w_idx = 32'(r_ptr) + k;
        if (w_idx >= NRQ) w_idx = w_idx - NRQ;
        w_i = GW'(w_idx);
        if (!w_accept && Req_Valid[w_i]) begin
          w_accept     = 1'b1;
          w_ready[w_i] = 1'b1;
          w_gidx       = w_i;
        end
      end
    end
  end

  // Select the granted request's fields and decode its address.
  always_comb begin
    w_ptr_next = (w_gidx == GW'(NRQ - 1)) ? '0 : w_gidx + 1'b1;
    w_sel_addr = Req_Addr[w_gidx*ADDR_W +: ADDR_W];
    w_sel_data = Req_Data[w_gidx*WIDTH +: WIDTH];
    w_addr_ok  = (32'(w_sel_addr) < NRG);
    w_onehot   = '0;
    for (int unsigned k = 0; k < NRG; k++) begin
      w_onehot[k] = w_addr_ok && (32'(w_sel_addr) == k);
    end
  end

  // Issue register, pointer update and completed-write counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr   <= '0;
      r_ld_en <= '0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_gid   <= '0;
      r_cnt   <= '0;
    end else begin
      if (|r_ld_en) r_cnt <= r_cnt + 16'd1;
      if (w_accept) begin
        r_ptr   <= w_ptr_next;
        r_ld_en <= w_onehot;
        r_err   <= !w_addr_ok;
        r_data  <= w_sel_data;
        r_gid   <= w_gidx;
      end else begin
        r_ld_en <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // An issue cycle that coincides with Reset is suppressed, so a write
  // accepted just before reset never reaches the register bank.
  assign LD_EN       = Reset ? '0 : r_ld_en;
  assign Err_Addr    = Reset ? 1'b0 : r_err;
  assign Req_Ready   = w_ready;
  assign Data_In     = r_data;
  assign Grant_Id    = r_gid;
  assign Write_Count = r_cnt;

endmodule

// File: tb/tb_lbm_reg_arbiter.sv
// Bench for lbm_reg_arbiter: directed vector table, hand sequences and
// randomized traffic against a behavioural model. Two instances share
// the stimulus: an 8-register bank and a 6-register bank.
module tb_lbm_reg_arbiter;

  logic         Clk;
  logic         Reset;
  logic         Hold;
  logic [3:0]   Req_Valid;
  logic [11:0]  Req_Addr;
  logic [127:0] Req_Data;

  logic [3:0]   Req_Ready,   Req_Ready6;
  logic [7:0]   LD_EN;
  logic [5:0]   LD_EN6;
  logic [31:0]  Data_In,     Data_In6;
  logic [1:0]   Grant_Id,    Grant_Id6;
  logic         Err_Addr,    Err_Addr6;
  logic [15:0]  Write_Count, Write_Count6;

  int checks   = 0;
  int failures = 0;

  lbm_reg_arbiter #(.WIDTH(32), .NUM_REQ(4), .NUM_REGS(8), .ADDR_W(3)) dut (
    .Clk(Clk), .Reset(Reset), .Hold(Hold), .Req_Valid(Req_Valid),
    .Req_Addr(Req_Addr), .Req_Data(Req_Data), .Req_Ready(Req_Ready),
    .LD_EN(LD_EN), .Data_In(Data_In), .Grant_Id(Grant_Id),
    .Err_Addr(Err_Addr), .Write_Count(Write_Count));

  lbm_reg_arbiter #(.WIDTH(32), .NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3)) dut6 (
    .Clk(Clk), .Reset(Reset), .Hold(Hold), .Req_Valid(Req_Valid),
    .Req_Addr(Req_Addr), .Req_Data(Req_Data), .Req_Ready(Req_Ready6),
    .LD_EN(LD_EN6), .Data_In(Data_In6), .Grant_Id(Grant_Id6),
    .Err_Addr(Err_Addr6), .Write_Count(Write_Count6));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register banks as the reg32 instances would hold them.
  logic [31:0] obs8 [8];
  logic [31:0] obs6 [6];
  always @(posedge Clk) begin
    for (int k = 0; k < 8; k++) if (LD_EN[k])  obs8[k] <= Data_In;
    for (int k = 0; k < 6; k++) if (LD_EN6[k]) obs6[k] <= Data_In6;
  end

  // Behavioural model state.
  int          m_ptr  = 0;
  logic        m_pend = 1'b0;
  logic [2:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_gid  = 0;
  logic [15:0] m_cnt  = '0;
  logic [15:0] m_cnt6 = '0;
  logic [31:0] mb8 [8];
  logic [31:0] mb6 [6];
  bit          wr8 [8];
  bit          wr6 [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_ready();
    logic [7:0] sh;
    if (Reset || Hold) return 4'b0;
    sh = {Req_Valid, Req_Valid} >> m_ptr;
    for (int j = 0; j < 4; j++) if (sh[j]) return 4'(1 << ((m_ptr + j) % 4));
    return 4'b0;
  endfunction

  task automatic model_update();
    logic [3:0] r;
    r = model_ready();
    if (Reset) begin
      m_ptr = 0; m_pend = 1'b0; m_data = '0; m_gid = 0; m_cnt = '0; m_cnt6 = '0;
      return;
    end
    if (m_pend) begin
      m_cnt++;
      mb8[m_addr] = m_data; wr8[m_addr] = 1'b1;
      if (m_addr < 6) begin
        m_cnt6++;
        mb6[m_addr] = m_data; wr6[m_addr] = 1'b1;
      end
    end
    m_pend = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        m_ptr  = (i + 1) % 4;
        m_gid  = i;
        m_data = Req_Data[i*32 +: 32];
        m_addr = Req_Addr[i*3 +: 3];
        m_pend = 1'b1;
      end
    end
  endtask

  // Sample on the falling edge and compare every output with the model.
  task automatic sample();
    logic [3:0] er;
    logic [7:0] el8;
    logic [5:0] el6;
    @(negedge Clk);
    er  = model_ready();
    el8 = (!Reset && m_pend) ? 8'(1 << m_addr) : 8'h0;
    el6 = (!Reset && m_pend && m_addr < 6) ? 6'(1 << m_addr) : 6'h0;
    chk("ready",    32'(Req_Ready),    32'(er));
    chk("ready6",   32'(Req_Ready6),   32'(er));
    chk("ld_en",    32'(LD_EN),        32'(el8));
    chk("ld_en6",   32'(LD_EN6),       32'(el6));
    chk("err",      32'(Err_Addr),     32'h0);
    chk("err6",     32'(Err_Addr6),    32'(!Reset && m_pend && m_addr >= 6));
    chk("data_in",  Data_In,           m_data);
    chk("data_in6", Data_In6,          m_data);
    chk("grant",    32'(Grant_Id),     32'(m_gid));
    chk("grant6",   32'(Grant_Id6),    32'(m_gid));
    chk("wcount",   32'(Write_Count),  32'(m_cnt));
    chk("wcount6",  32'(Write_Count6), 32'(m_cnt6));
  endtask

  task automatic advance();
    model_update();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_banks();
    for (int k = 0; k < 8; k++) if (wr8[k]) chk($sformatf("bank8[%0d]", k), obs8[k], mb8[k]);
    for (int k = 0; k < 6; k++) if (wr6[k]) chk($sformatf("bank6[%0d]", k), obs6[k], mb6[k]);
  endtask

  typedef struct {
    logic         rst;
    logic         hold;
    logic [3:0]   valid;
    logic [11:0]  addr;
    logic [127:0] data;
    logic [3:0]   e_rdy;
    logic [7:0]   e_ld;
    logic [15:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic hold, input logic [3:0] valid,
                              input logic [11:0] addr, input logic [127:0] data,
                              input logic [3:0] e_rdy, input logic [7:0] e_ld,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rst = rst; v.hold = hold; v.valid = valid; v.addr = addr; v.data = data;
    v.e_rdy = e_rdy; v.e_ld = e_ld; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t tbl [$];

  localparam logic [11:0]  A_STD = {3'd7, 3'd6, 3'd5, 3'd4};
  localparam logic [127:0] D_STD = {32'h1003, 32'h1002, 32'h1001, 32'h1000};
  localparam logic [11:0]  A_T2  = {3'd7, 3'd6, 3'd5, 3'd3};
  localparam logic [127:0] D_T2  = {32'h1003, 32'h1002, 32'h1001, 32'h0012_3456};

  logic [7:0]  ld_seq  [8] = '{8'h00, 8'h10, 8'h20, 8'h40, 8'h80, 8'h10, 8'h20, 8'h40};
  logic [15:0] cnt_seq [8] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
  logic [15:0] s8, s6;

  initial begin
    // Reset held with every requester valid, then single write,
    // full round-robin sweep after a reset, then Hold barrier.
    tbl.push_back(mk(1, 0, 4'hF, A_STD, D_STD, 4'h0, 8'h00, 16'd0));
    tbl.push_back(mk(1, 0, 4'hF, A_STD, D_STD, 4'h0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 4'h1, A_T2,  D_T2,  4'h1, 8'h00, 16'd0));
    tbl.push_back(mk(0, 0, 4'h0, A_T2,  D_T2,  4'h0, 8'h08, 16'd0));
    tbl.push_back(mk(0, 0, 4'h0, A_T2,  D_T2,  4'h0, 8'h00, 16'd1));
    tbl.push_back(mk(1, 0, 4'hF, A_STD, D_STD, 4'h0, 8'h00, 16'd1));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 0, 4'hF, A_STD, D_STD, 4'(1 << (k % 4)), ld_seq[k], cnt_seq[k]));
    tbl.push_back(mk(0, 0, 4'h0, A_STD, D_STD, 4'h0, 8'h80, 16'd7));
    tbl.push_back(mk(0, 0, 4'h0, A_STD, D_STD, 4'h0, 8'h00, 16'd8));
    tbl.push_back(mk(0, 0, 4'h4, A_STD, D_STD, 4'h4, 8'h00, 16'd8));
    tbl.push_back(mk(0, 1, 4'h4, A_STD, D_STD, 4'h0, 8'h40, 16'd8));
    tbl.push_back(mk(0, 1, 4'h4, A_STD, D_STD, 4'h0, 8'h00, 16'd9));
    tbl.push_back(mk(0, 1, 4'h4, A_STD, D_STD, 4'h0, 8'h00, 16'd9));
    tbl.push_back(mk(0, 0, 4'h4, A_STD, D_STD, 4'h4, 8'h00, 16'd9));
    tbl.push_back(mk(0, 0, 4'h0, A_STD, D_STD, 4'h0, 8'h40, 16'd9));
    tbl.push_back(mk(0, 0, 4'h0, A_STD, D_STD, 4'h0, 8'h00, 16'd10));

    Reset = 1'b1; Hold = 1'b0; Req_Valid = 4'hF; Req_Addr = A_STD; Req_Data = D_STD;
    @(posedge Clk);
    #1;

    foreach (tbl[i]) begin
      Reset = tbl[i].rst; Hold = tbl[i].hold; Req_Valid = tbl[i].valid;
      Req_Addr = tbl[i].addr; Req_Data = tbl[i].data;
      sample();
      chk($sformatf("vec%0d_ready", i), 32'(Req_Ready),   32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_ld_en", i), 32'(LD_EN),       32'(tbl[i].e_ld));
      chk($sformatf("vec%0d_count", i), 32'(Write_Count), 32'(tbl[i].e_cnt));
      advance();
    end
    chk("reg3", obs8[3], 32'h0012_3456);
    chk("reg6", obs8[6], 32'h0000_1002);
    chk("reg7", obs8[7], 32'h0000_1003);

    // Same address from consecutive grants: later data wins.
    Reset = 1'b0; Hold = 1'b0;
    Req_Addr = {3'd7, 3'd0, 3'd7, 3'd0};
    Req_Data = {32'h0000_0010, 32'h0, 32'hFFFF_FFFB, 32'h0};
    Req_Valid = 4'b0010;
    sample(); chk("b2b_ready1", 32'(Req_Ready), 32'h2); advance();
    Req_Valid = 4'b1000;
    sample();
    chk("b2b_ready3", 32'(Req_Ready), 32'h8);
    chk("b2b_ld1",    32'(LD_EN),     32'h80);
    chk("b2b_data1",  Data_In,        32'hFFFF_FFFB);
    advance();
    Req_Valid = 4'b0000;
    sample();
    chk("b2b_ld2",   32'(LD_EN), 32'h80);
    chk("b2b_data2", Data_In,    32'h0000_0010);
    advance();
    chk("b2b_reg7", obs8[7], 32'h0000_0010);

    // Out-of-range address on the 6-register bank.
    Req_Addr = {3'd0, 3'd0, 3'd0, 3'd6}; Req_Data = {96'h0, 32'h0000_0ABC};
    Req_Valid = 4'b0001;
    sample();
    chk("err_ready", 32'(Req_Ready6), 32'h1);
    s8 = m_cnt; s6 = m_cnt6;
    advance();
    Req_Valid = 4'b0000;
    sample();
    chk("err_pulse6", 32'(Err_Addr6), 32'h1);
    chk("err_ld6",    32'(LD_EN6),    32'h0);
    chk("err_ld8",    32'(LD_EN),     32'h40);
    advance();
    sample();
    chk("err_clear6",  32'(Err_Addr6),    32'h0);
    chk("err_count6",  32'(Write_Count6), 32'(s6));
    chk("err_count8",  32'(Write_Count),  32'(s8 + 16'd1));
    advance();

    // Reset the cycle after an accept: the write never appears.
    Req_Addr = {3'd0, 3'd0, 3'd0, 3'd2}; Req_Valid = 4'b0001;
    sample(); chk("rst_acc_ready", 32'(Req_Ready), 32'h1); advance();
    Reset = 1'b1; Req_Valid = 4'b0000;
    sample();
    chk("rst_ld",    32'(LD_EN),     32'h0);
    chk("rst_ld6",   32'(LD_EN6),    32'h0);
    chk("rst_ready", 32'(Req_Ready), 32'h0);
    advance();
    Reset = 1'b0;
    sample();
    chk("post_rst_ld",    32'(LD_EN),       32'h0);
    chk("post_rst_count", 32'(Write_Count), 32'h0);
    chk("post_rst_grant", 32'(Grant_Id),    32'h0);
    advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      Reset     = ($urandom_range(0, 49) == 0);
      Hold      = ($urandom_range(0, 5) == 0);
      Req_Valid = 4'($urandom);
      Req_Addr  = 12'($urandom);
      Req_Data  = {$urandom, $urandom, $urandom, $urandom};
      sample();
      advance();
    end
    Reset = 1'b0; Hold = 1'b0; Req_Valid = 4'b0;
    sample(); advance();
    sample(); advance();
    check_banks();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbm_reg_arbiter.md
Name: lbm_reg_arbiter

Overview:
- Round-robin write arbiter that shares one bank of NUM_REGS signed reg32 registers among NUM_REQ requesters (the LBM collision/streaming engines and the host config path).
- Each cycle it grants at most one valid write request and drives the shared signed Data_In bus plus a one-hot LD_EN vector for one cycle.
- Sits between the requesters and the reg32 instances. Each reg32 keeps its own Clk/Reset; its LD_EN comes from this block.

Parameters:
- WIDTH, 32, data width of each register and of Data_In.
- NUM_REQ, 4, number of requesters (2..8).
- NUM_REGS, 8, number of registers in the bank.
- ADDR_W, 3, register address width; must satisfy 2^ADDR_W >= NUM_REGS.

Ports:
- Clk  in  1  system clock (50 MHz); all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Hold  in  1  pause new grants (phase barrier); in-flight write still completes.
- Req_Valid  in  NUM_REQ  per-requester write request.
- Req_Addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- Req_Data  in  NUM_REQ*WIDTH  packed signed data; requester i at [i*WIDTH +: WIDTH].
- Req_Ready  out  NUM_REQ  one-hot accept strobe; transfer when Req_Valid[i] & Req_Ready[i].
- LD_EN  out  NUM_REGS  one-hot load enable to the register bank (registered).
- Data_In  out  WIDTH  signed write data to the register bank (registered).
- Grant_Id  out  $clog2(NUM_REQ)  index of the last accepted requester (registered).
- Err_Addr  out  1  one-cycle pulse: the accepted request had Req_Addr >= NUM_REGS.
- Write_Count  out  16  number of completed register writes; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (synchronous, Reset=1 at rising edge) clears:
  - LD_EN=0, Data_In=0, Grant_Id=0, Err_Addr=0, Write_Count=0.
  - Round-robin pointer=0.
  - Any accepted but not yet issued write is discarded.
- Req_Ready is combinational from Req_Valid, Hold, Reset and the registered pointer.
  - At most one bit set.
  - All zero when Reset=1 or Hold=1.
- Arbitration:
  - Search Req_Valid starting at the pointer index, wrapping modulo NUM_REQ.
  - The first valid requester found gets Req_Ready.
  - On accept, pointer <= granted index + 1 (mod NUM_REQ).
  - No accept -> pointer unchanged.
- Requesters hold Valid/Addr/Data stable until they see Ready. Dropping Valid before Ready is legal; the request is simply not taken.
- Issue pipeline, for accept at edge N (Valid&Ready sampled high):
  - Cycle N+1, addr < NUM_REGS: LD_EN = one-hot(addr), Data_In = Req_Data[i], Grant_Id = i, all for exactly one cycle.
  - Cycle N+1, addr >= NUM_REGS: LD_EN stays 0, Err_Addr=1 for one cycle, Grant_Id=i.
  - Edge ending N+1: reg32 captures; Write_Count increments for valid writes only.
  - Reg Data_Out reflects the new value after that edge, 2 cycles after accept.
- Outside an issue cycle: LD_EN=0, Err_Addr=0, Data_In holds its last value.
- Back-to-back: one accept per cycle. Sustained throughput is 1 write/cycle, with LD_EN pulses in consecutive cycles.
- Same address from consecutive grants: both issued in order; the later data wins.
- Hold asserted in the same cycle as Valid: no accept. A write accepted in the previous cycle still issues.
- Single requester continuously valid: granted every cycle (no idle cycle forced).
- Data_In is passed through unmodified (signed, no extension or truncation).
- Reset asserted mid-stream: the cycle after the reset edge shows LD_EN=0 and Write_Count=0, even if a grant occurred in the reset cycle.

Test Plan:
- Reset=1 for 2 cycles with all Req_Valid=1 -> Req_Ready=0, LD_EN=0, Data_In=0, Write_Count=0; after release, first grant goes to requester 0.
- Req_Valid=4'b0001, addr=3, data=32'h0012_3456 -> Req_Ready[0] one cycle; next cycle LD_EN=8'h08, Data_In=32'h0012_3456; reg3 Data_Out=32'h0012_3456 one cycle later; Write_Count=1.
- Req_Valid=4'b1111 held for 8 cycles, each requester writing its own address -> grant order 0,1,2,3,0,1,2,3; LD_EN pulses every cycle; Write_Count=8.
- Hold=1 for 3 cycles with Req_Valid=4'b0100 -> Req_Ready=0 throughout; after Hold drops, requester 2 is granted next cycle; a write accepted just before Hold still issues.
- Requester 1 addr=7 data=-5 (32'hFFFF_FFFB), requester 3 addr=7 data=32'h0000_0010 back-to-back -> two LD_EN=8'h80 pulses; reg7 ends at 32'h0000_0010.
- With NUM_REGS=6, addr=6 accepted -> Err_Addr pulse, LD_EN=0, Write_Count unchanged. Separately: Reset asserted the cycle after an accept -> no LD_EN pulse is observed.
